// File: rtl/multicycle_alu_pkg.sv
// Shared types for the multi-cycle ALU: function codes, handshake FSM states
// and the helper that separates single-cycle from iterative operations.
package multicycle_alu_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        NOR   = 4'd4,
        XOR   = 4'd5,
        SLTU  = 4'd6,
        LUI   = 4'd7,
        MUL   = 4'd8,
        MULHU = 4'd9,
        DIVU  = 4'd10,
        REMU  = 4'd11,
        RSV12 = 4'd12,
        RSV13 = 4'd13,
        RSV14 = 4'd14,
        RSV15 = 4'd15
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Codes 8..11 (MUL, MULHU, DIVU, REMU) go through the iteration unit.
    function automatic logic is_iterative(input logic [3:0] func);
        return func[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/multicycle_alu_iter.sv
// Shared shift-add multiplier / restoring divider for the multi-cycle ALU.
// One step per cycle for WIDTH cycles; done flags the cycle of the final step.
module alu_iter_unit
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] work_q;
    logic [2*WIDTH-1:0] work_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    assign busy = (count_q != '0);
    assign done = busy && (count_q == CNT_W'(1));

    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        work_d    = work_q;
        if (!op_q[1]) begin
            work_d = {mul_sum, work_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end else begin
            work_d = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        end
    end

    // MULHU and REMU take the upper half; MUL and DIVU the lower half.
    assign res = op_q[0] ? work_d[2*WIDTH-1:WIDTH] : work_d[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
        end else if (start) begin
            op_q    <= op;
            count_q <= CNT_W'(WIDTH);
            if (!op[1]) begin
                work_q <= {{WIDTH{1'b0}}, b};
                opnd_q <= a;
            end else begin
                work_q <= {{WIDTH{1'b0}}, a};
                opnd_q <= b;
            end
        end else if (busy) begin
            work_q  <= work_d;
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU top: valid/ready handshake FSM, single-cycle op logic and
// registered result/flags, with MUL/DIV delegated to alu_iter_unit.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             err_flag
);

    alu_state_t       state_q;
    alu_state_t       state_d;
    alu_func_t        func_sel;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic             iter_start;
    logic             iter_busy;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             div_zero_q;

    assign func_sel = alu_func_t'(func);

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (func_sel)
            ADD:     single_res = a + b;
            SUB:     single_res = a - b;
            AND:     single_res = a & b;
            OR:      single_res = a | b;
            NOR:     single_res = ~(a | b);
            XOR:     single_res = a ^ b;
            SLTU:    single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            LUI:     single_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: single_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        iter_start = 1'b0;
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_iterative(func)) begin
                        iter_start = 1'b1;
                        state_d    = BUSY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (iter_busy && iter_done) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Result and both flags are captured together; divide-by-zero is noted at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            zero_flag  <= 1'b0;
            err_flag   <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            if (is_iterative(func)) begin
                div_zero_q <= func[1] && (b == '0);
            end else begin
                result    <= single_res;
                zero_flag <= (single_res == '0);
                err_flag  <= single_err;
            end
        end else if (state_q == BUSY && iter_busy && iter_done) begin
            result    <= iter_res;
            zero_flag <= (iter_res == '0);
            err_flag  <= div_zero_q;
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (iter_start),
        .op    (func[1:0]),
        .a     (a),
        .b     (b),
        .busy  (iter_busy),
        .done  (iter_done),
        .res   (iter_res)
    );

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised next-generation ALU for the multi-cycle CPU datapath.
- Keeps the 8 single-cycle ops and adds iterative unsigned multiply (low/high) and divide/remainder.
- Operands enter through a valid/ready handshake.
- The registered result leaves through a valid/ready handshake with zero and error flags.
- Sits between the register-read stage and the writeback mux; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits; even, minimum 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and func are valid this cycle.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- func  in  4  operation select; encoding below.
- out_valid  out  1  result/flags valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero_flag  out  1  registered; 1 when result==0.
- err_flag  out  1  registered; 1 for divide-by-zero or reserved func.

Behaviour:
- Func encoding:
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 NOR ~(a|b); 5 XOR.
  - 6 SLTU: (a<b unsigned) ? 1 : 0.
  - 7 LUI: b[WIDTH/2-1:0] placed in the upper half, lower half 0.
  - 8 MUL: low WIDTH bits of a*b. 9 MULHU: high WIDTH bits of unsigned a*b.
  - 10 DIVU: a/b. 11 REMU: a%b.
  - 12-15 reserved.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid (in_ready already 1); a, b, func are latched at acceptance.
  - func 0-7 and 12-15: result computed and registered in the accept cycle, go to DONE.
  - func 8-11: load iteration registers, counter=WIDTH, go to BUSY.
- BUSY:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - When counter reaches 1, that step completes and the state moves to DONE.
  - Iterative latency: accept at cycle T gives out_valid at T+WIDTH+1. Single-cycle ops give out_valid at T+1.
- DONE:
  - out_valid=1; result, zero_flag and err_flag stable.
  - out_ready=1 gives IDLE next cycle.
  - No accept in DONE: minimum back-to-back spacing is 2 cycles for single-cycle ops.
- Input changes after acceptance have no effect.
- in_valid is ignored outside IDLE.
- Divide by zero (b==0):
  - DIVU result all-ones; REMU result = a; err_flag=1.
  - Still takes the full WIDTH+1 latency.
- Reserved func: result 0, zero_flag=1, err_flag=1, latency 1.
- MUL and MULHU both run the full 2*WIDTH product; the selected half is returned.
- Reset (asynchronous, any state including mid-BUSY):
  - State IDLE, in_ready=1, out_valid=0, result=0, zero_flag=0, err_flag=0, counter=0.
  - An in-flight operation is discarded.
- zero_flag and err_flag are registered together with result; never combinational from result.

Decomposition:
- Package multicycle_alu_pkg:
  - alu_func_t enum with the 16 codes: ADD, SUB, AND, OR, NOR, XOR, SLTU, LUI, MUL, MULHU, DIVU, REMU, RSV12-15.
  - alu_state_t enum IDLE/BUSY/DONE.
  - Helper function is_iterative(func).
- One sub-module, alu_iter_unit: the shift-add multiplier and restoring divider sharing the counter.
  - Interface: start, op[1:0], a, b, busy, done, res.
  - The top holds the handshake FSM and the combinational single-cycle op logic.

Test Plan:
- Reset mid-BUSY: start DIVU a=100, b=7; drop rst_n 5 cycles later -> in_ready=1, out_valid=0, result=0 immediately (asynchronous); next accepted op behaves normally.
- Single-cycle ops, WIDTH=32:
  - SUB 5-5 -> result 0, zero_flag=1, out_valid one cycle after accept.
  - SLTU 3,0xFFFFFFFF -> 1.
  - LUI b=0x00001234 -> 0x12340000.
  - NOR 0,0 -> 0xFFFFFFFF.
- MUL and MULHU:
  - MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same operands -> 0x00000001.
  - out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU and REMU:
  - DIVU 100/7 -> 14; REMU -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF, err_flag=1; REMU 5/0 -> 5, err_flag=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and flags stable, in_ready=0, new in_valid ignored; raise out_ready -> IDLE next cycle.
- Reserved and WIDTH=8 variant:
  - func=13 -> result 0, err_flag=1, zero_flag=1.
  - WIDTH=8: MUL 15*17 -> 0xFF, latency 9; LUI b=0xAB -> 0xB0.
